// File: rtl/dp_mem_responder.sv
// Responder for the datapath-cache request interface: serialises instruction
// fetches and data reads/writes onto a single-port RAM of variable latency.
module dp_mem_responder #(
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_store,
    input  logic [WORD_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  store_q, store_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0]  iload_q, iload_d;
    logic [WORD_W-1:0]  dload_q, dload_d;
    logic               timeout_q, timeout_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            kind_q    <= IFETCH;
            addr_q    <= '0;
            store_q   <= '0;
            cnt_q     <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            cnt_q     <= cnt_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        addr_d    = addr_q;
        store_d   = store_q;
        cnt_d     = cnt_q;
        iload_d   = iload_q;
        dload_d   = dload_q;
        timeout_d = timeout_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Data wins over fetch; a simultaneous REN+WEN counts as a write.
                cnt_d = '0;
                if (dmemWEN) begin
                    kind_d  = DWRITE;
                    addr_d  = dmemaddr;
                    store_d = dmemstore;
                    state_d = ACCESS;
                end else if (dmemREN) begin
                    kind_d  = DREAD;
                    addr_d  = dmemaddr;
                    state_d = ACCESS;
                end else if (imemREN && !halt) begin
                    kind_d  = IFETCH;
                    addr_d  = imemaddr;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                ram_ren = (kind_q != DWRITE);
                ram_wen = (kind_q == DWRITE);
                if (ram_ready) begin
                    if (kind_q == IFETCH) iload_d = ram_load;
                    if (kind_q == DREAD)  dload_d = ram_load;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                    if (MAX_WAIT > 0 && cnt_d == WAIT_W'(MAX_WAIT)) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end

            RESP: begin
                // A requester that gave up gets no hit; the access itself stands.
                unique case (kind_q)
                    IFETCH:  ihit = imemREN;
                    DREAD:   dhit = dmemREN;
                    DWRITE:  dhit = dmemWEN;
                    default: ;
                endcase
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_store = store_q;
    assign imemload  = iload_q;
    assign dmemload  = dload_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Self-checking bench for dp_mem_responder: directed vector table, multi-cycle
// corner sequences and a randomized run checked against a memory-level model.
module tb_dp_mem_responder;
    localparam int WORD_W = 32, ADDR_W = 32, MAX_WAIT = 8, WAIT_W = 8;

    logic              CLK = 1'b0, nRST = 1'b0, halt = 1'b0;
    logic              imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
    logic [ADDR_W-1:0] imemaddr = '0, dmemaddr = '0;
    logic [WORD_W-1:0] dmemstore = '0;
    logic              ihit, dhit, ram_ren, ram_wen, ram_ready, timeout;
    logic [WORD_W-1:0] imemload, dmemload, ram_store, ram_load;
    logic [ADDR_W-1:0] ram_addr;

    always #5 CLK = ~CLK;

    dp_mem_responder #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready), .timeout(timeout)
    );

    // Initial RAM image: two fixed words used by the directed cases, a pattern elsewhere.
    function automatic logic [31:0] seed(input logic [7:0] i);
        if (i == 8'h00) return 32'h2002000A;
        if (i == 8'h20) return 32'h00001234;
        return 32'hC0DE0000 | {24'h0, i};
    endfunction

    // RAM model: ready after ram_wait_cfg wait cycles of a strobe, unless stuck.
    logic [31:0] ram_mem [256];
    logic        ram_wr  [256];
    int          ram_wait_cfg = 0;
    bit          ram_stuck = 1'b0;
    int          acc_cyc = 0;

    always_comb begin
        ram_load  = ram_wr[ram_addr[9:2]] ? ram_mem[ram_addr[9:2]] : seed(ram_addr[9:2]);
        ram_ready = !ram_stuck && (ram_ren || ram_wen) && (acc_cyc >= ram_wait_cfg);
    end

    always @(posedge CLK) begin
        if ((ram_ren || ram_wen) && !ram_ready) acc_cyc <= acc_cyc + 1;
        else acc_cyc <= 0;
        if (ram_wen && ram_ready) begin
            ram_mem[ram_addr[9:2]] <= ram_store;
            ram_wr[ram_addr[9:2]]  <= 1'b1;
        end
    end

    // Reference memory as the datapath should see it.
    logic [31:0] ref_mem [256];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            chk("excl_hits", {31'b0, ihit && dhit}, 32'd0);
            chk("excl_strobes", {31'b0, ram_ren && ram_wen}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic clr_req();
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    // kind: 0 = ifetch, 1 = data read, 2 = data write
    task automatic set_req(input int kind, input logic [31:0] a, input logic [31:0] s);
        case (kind)
            0: begin imemREN = 1'b1; imemaddr = a; end
            1: begin dmemREN = 1'b1; dmemaddr = a; end
            default: begin dmemWEN = 1'b1; dmemaddr = a; dmemstore = s; end
        endcase
    endtask

    // Issue one request from IDLE and wait for its hit; latency counted in edges.
    task automatic run_one(input int kind, input logic [31:0] a, input logic [31:0] s,
                           output int lat, output int strobes, output int bad);
        lat = -1; strobes = 0; bad = 0;
        set_req(kind, a, s);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ram_ren || ram_wen) begin
                strobes++;
                if (ram_addr !== a || ram_wen !== (kind == 2) || (kind == 2 && ram_store !== s)) bad++;
            end
            if ((kind == 0 && ihit) || (kind != 0 && dhit)) begin lat = n; break; end
        end
        clr_req();
        tick();
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] store;
        int          waits;
        int          exp_lat;
        logic [31:0] exp_iload;
        logic [31:0] exp_dload;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int lat, st, bad, cnt, hits, ilat, dlat;
        for (int i = 0; i < 256; i++) begin
            ram_wr[i]  = 1'b0;
            ref_mem[i] = seed(8'(i));
        end

        tbl[0] = '{0, 32'h0,   32'h0,        0, 2, 32'h2002000A, 32'h0};
        tbl[1] = '{1, 32'h80,  32'h0,        5, 7, 32'h2002000A, 32'h1234};
        tbl[2] = '{2, 32'h100, 32'hDEADBEEF, 0, 2, 32'h2002000A, 32'h1234};
        tbl[3] = '{1, 32'h100, 32'h0,        1, 3, 32'h2002000A, 32'hDEADBEEF};
        tbl[4] = '{0, 32'h3FC, 32'h0,        3, 5, seed(8'hFF),  32'hDEADBEEF};

        #12;
        chk("rst_ihit", {31'b0, ihit}, 0);
        chk("rst_dhit", {31'b0, dhit}, 0);
        chk("rst_ren_wen", {30'b0, ram_ren, ram_wen}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_loads", imemload | dmemload | ram_store, 0);
        chk("rst_timeout", {31'b0, timeout}, 0);
        @(negedge CLK); nRST = 1'b1;
        tick();

        foreach (tbl[i]) begin
            ram_wait_cfg = tbl[i].waits;
            run_one(tbl[i].kind, tbl[i].addr, tbl[i].store, lat, st, bad);
            if (tbl[i].kind == 2) ref_mem[tbl[i].addr[9:2]] = tbl[i].store;
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_strobes", i), st, tbl[i].waits + 1);
            chk($sformatf("vec%0d_ram_if", i), bad, 0);
            chk($sformatf("vec%0d_iload", i), imemload, tbl[i].exp_iload);
            chk($sformatf("vec%0d_dload", i), dmemload, tbl[i].exp_dload);
        end

        // Simultaneous fetch and write: write first, fetch 3 cycles after dhit.
        ram_wait_cfg = 0; ilat = -1; dlat = -1; bad = 0; cnt = 0;
        set_req(0, 32'h4, 0);
        set_req(2, 32'h100, 32'hDEADBEEF);
        for (int n = 1; n <= 30 && ilat < 0; n++) begin
            tick();
            if ((ram_ren || ram_wen) && cnt++ == 0)
                if (!ram_wen || ram_addr !== 32'h100 || ram_store !== 32'hDEADBEEF) bad++;
            if (dhit) begin dlat = n; dmemWEN = 1'b0; end
            if (ihit) begin ilat = n; imemREN = 1'b0; end
        end
        tick();
        ref_mem[8'h40] = 32'hDEADBEEF;
        chk("simul_first_write", bad, 0);
        chk("simul_dhit_lat", dlat, 2);
        chk("simul_ihit_gap", ilat - dlat, 3);
        chk("simul_iload", imemload, seed(8'h01));

        // Fetch in flight when halt rises still completes.
        ram_wait_cfg = 3; lat = -1;
        set_req(0, 32'hC, 0);
        tick();
        halt = 1'b1;
        for (int n = 2; n <= 30; n++) begin
            tick();
            if (ihit) begin lat = n; break; end
        end
        clr_req();
        tick();
        chk("halt_inflight_lat", lat, 5);
        chk("halt_inflight_iload", imemload, seed(8'h03));

        // Halt blocks new fetches, data still served.
        ram_wait_cfg = 0; cnt = 0; hits = 0;
        set_req(0, 32'h8, 0);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ram_ren) cnt++;
            if (ihit) hits++;
        end
        chk("halt_no_ren", cnt, 0);
        chk("halt_no_ihit", hits, 0);
        dlat = -1;
        set_req(2, 32'h200, 32'h55AA55AA);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (dhit) begin dlat = n; dmemWEN = 1'b0; break; end
        end
        tick();
        ref_mem[8'h80] = 32'h55AA55AA;
        chk("halt_dwrite_lat", dlat, 2);
        halt = 1'b0; ilat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ihit) begin ilat = n; break; end
        end
        clr_req();
        tick();
        chk("unhalt_ihit_lat", ilat, 2);
        chk("unhalt_iload", imemload, seed(8'h02));

        // Watchdog: stuck RAM, 8 strobe cycles, sticky timeout, no hit.
        ram_stuck = 1'b1; cnt = 0; hits = 0;
        set_req(1, 32'h40, 0);
        for (int n = 0; n < 30; n++) begin
            tick();
            if (dhit) hits++;
            if (ram_ren) cnt++;
            else if (cnt > 0) break;
        end
        clr_req();
        ram_stuck = 1'b0;
        chk("wdog_ren_cycles", cnt, MAX_WAIT);
        chk("wdog_no_dhit", hits, 0);
        chk("wdog_timeout", {31'b0, timeout}, 1);
        tick();
        run_one(0, 32'h10, 0, lat, st, bad);
        chk("wdog_after_lat", lat, 2);
        chk("wdog_after_iload", imemload, seed(8'h04));
        chk("wdog_sticky", {31'b0, timeout}, 1);

        // Reset in the middle of a data read.
        ram_wait_cfg = 5;
        set_req(1, 32'h80, 0);
        tick(); tick();
        nRST = 1'b0; #1;
        chk("mid_rst_strobes", {30'b0, ram_ren, ram_wen}, 0);
        chk("mid_rst_hits", {30'b0, ihit, dhit}, 0);
        chk("mid_rst_loads", imemload | dmemload, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_timeout", {31'b0, timeout}, 0);
        clr_req();
        @(negedge CLK); nRST = 1'b1;
        hits = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (dhit || ihit) hits++;
        end
        chk("post_rst_no_hit", hits, 0);
        chk("post_rst_dload", dmemload, 0);
        ram_wait_cfg = 0;
        run_one(1, 32'h80, 0, lat, st, bad);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_dload2", dmemload, 32'h1234);

        // Randomized: optional fetch plus optional data op, checked against ref_mem.
        for (int it = 0; it < 150; it++) begin
            int w, dk, want_i;
            logic [31:0] ia, da, ds, exp_i, exp_d;
            bit d_done;
            w = int'($urandom_range(0, 3));
            dk = int'($urandom_range(0, 2));
            want_i = int'($urandom_range(0, 1));
            if (dk == 0) want_i = 1;
            ia = 32'($urandom_range(0, 255)) << 2;
            da = 32'($urandom_range(0, 255)) << 2;
            ds = $urandom;
            exp_d = (dk == 1) ? ref_mem[da[9:2]] : dmemload;
            if (dk == 2) ref_mem[da[9:2]] = ds;
            exp_i = want_i ? ref_mem[ia[9:2]] : imemload;
            ram_wait_cfg = w;
            ilat = -1; dlat = -1; bad = 0; d_done = (dk == 0);
            if (want_i != 0) set_req(0, ia, 0);
            if (dk != 0) set_req(dk, da, ds);
            for (int n = 1; n <= 60; n++) begin
                tick();
                if (ram_ren || ram_wen) begin
                    if (!d_done && (ram_addr !== da || ram_wen !== (dk == 2) ||
                                    (dk == 2 && ram_store !== ds))) bad++;
                    if (d_done && (ram_addr !== ia || ram_wen !== 1'b0)) bad++;
                end
                if (dhit) begin dlat = n; d_done = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; end
                if (ihit) begin ilat = n; imemREN = 1'b0; end
                if (d_done && (want_i == 0 || ilat > 0)) break;
            end
            clr_req();
            tick();
            chk($sformatf("rnd%0d_ram_if", it), bad, 0);
            if (dk != 0) chk($sformatf("rnd%0d_dlat", it), dlat, 2 + w);
            chk($sformatf("rnd%0d_ilat", it), ilat,
                want_i == 0 ? -1 : (dk != 0 ? 5 + 2 * w : 2 + w));
            chk($sformatf("rnd%0d_dload", it), dmemload, exp_d);
            chk($sformatf("rnd%0d_iload", it), imemload, exp_i);
        end
        chk("rnd_no_timeout", {31'b0, timeout}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 1000000");
        $fatal(1, "bench time limit");
    end

endmodule
